mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates a fetch port and a data port onto one variable-latency
//            memory port with one transaction outstanding. Data wins over
//            fetch. Defining ARB_STARVE_GUARD_EN adds a defer counter that
//            forces a fetch grant after MAX_DEFER consecutive deferrals.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_DEFER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_op,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        i_stall,
    output logic        d_stall
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [1:0]  m_op_q, m_op_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;

    logic        w_force_i;
    logic        w_grant_i;
    logic        w_grant_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] c_max_defer = 3'(MAX_DEFER);

    logic [2:0] defer_q, defer_d;

    // Fetch wins a collision once it has been passed over MAX_DEFER times in a row.
    assign w_force_i = i_req && d_req && (defer_q == c_max_defer);

    always_comb begin
        defer_d = defer_q;
        if (w_grant_d) begin
            defer_d = i_req ? (defer_q + 3'd1) : 3'd0;
        end else if (w_grant_i) begin
            defer_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            defer_q <= 3'd0;
        end else begin
            defer_q <= defer_d;
        end
    end
`else
    logic unused_max_defer;

    assign w_force_i        = 1'b0;
    assign unused_max_defer = |MAX_DEFER;
`endif

    assign w_grant_d = (state_q == IDLE) && d_req && !w_force_i;
    assign w_grant_i = (state_q == IDLE) && i_req && (!d_req || w_force_i);

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_op_d    = m_op_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_op_d    = d_op;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (w_grant_i) begin
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_op_d    = 2'd0;
                    m_addr_d  = i_addr;
                    m_wdata_d = 32'd0;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    state_d   = RESP;
                    m_req_d   = 1'b0;
                    i_rdata_d = m_rdata;
                    i_done_d  = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    state_d   = RESP;
                    m_req_d   = 1'b0;
                    d_rdata_d = m_rdata;
                    d_done_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_op_q    <= 2'd0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_op_q    <= m_op_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_op    = m_op_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule
`default_nettype wire
